// File: rtl/pps_elapsed_timer_pkg.sv
// Shared types for the PPS elapsed-time counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pps_timer_pkg;

  // Discipline state of the tick counter, as reported on pps_state.
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_HOLDOVER = 2'd2
  } pps_state_t;

  // Width of the saturating rejected-edge counter.
  localparam int GLITCH_W = 16;

endpackage

// File: rtl/pps_elapsed_timer_if.sv
// Trigger-in / timestamp-out bundle between the timer and capture logic.
// Latency: timestamps appear one cycle after a trig rising edge.
// Backpressure: none; each ts_valid strobe is a 1-cycle pulse.
interface pps_elapsed_timer_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 29,
  parameter int SEC_W = 32
);
  logic [N_CH-1:0]       trig;
  logic [N_CH-1:0]       ts_valid;
  logic [N_CH*CNT_W-1:0] ts_elapsed;
  logic [N_CH*SEC_W-1:0] ts_seconds;

  // Timer side: samples triggers, produces timestamps.
  modport master (input trig, output ts_valid, ts_elapsed, ts_seconds);
  // Capture side: raises triggers, consumes timestamps.
  modport slave  (output trig, input ts_valid, ts_elapsed, ts_seconds);
endinterface

// File: rtl/pps_edge_sync.sv
// Synchroniser chain plus rising-edge detector for an asynchronous pulse.
// Latency: rise asserts STAGES cycles after async_in is first sampled high.
// Backpressure: none; rise is a single-cycle pulse per rising edge.
module pps_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              dly_q, dly_d;

  // Shift the input through the chain; one extra flop gives the edge reference.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    dly_d  = sync_q[STAGES-1];
    rise   = sync_q[STAGES-1] & ~dly_q;
  end

  // Chain and delay registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end
endmodule

// File: rtl/pps_elapsed_timer.sv
// PPS-disciplined tick/seconds counter with lock/holdover and trigger timestamps.
// Latency: counter reacts 2+SYNC_STAGES-1 cycles after PPS; timestamps 1 cycle after trig.
// Backpressure: none; all outputs are free-running registers or 1-cycle strobes.
module pps_elapsed_timer
  import pps_timer_pkg::*;
#(
  parameter int CNT_W       = 29,
  parameter int SEC_W       = 32,
  parameter int NOM_TICKS   = 250000000,
  parameter int TOL         = 1000,
  parameter int LOCK_N      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int N_CH        = 4
) (
  input  logic                clk_250,
  input  logic                rst,
  input  logic                one_pps,
  input  logic                sec_load,
  input  logic [SEC_W-1:0]    sec_load_val,
  output logic [CNT_W-1:0]    elapsed_time,
  output logic [SEC_W-1:0]    seconds,
  output logic [CNT_W-1:0]    last_period,
  output logic [1:0]          pps_state,
  output logic                pps_locked,
  output logic                pps_missing,
  output logic [GLITCH_W-1:0] glitch_count,
  pps_elapsed_timer_if.master ts
);
  localparam int CONS_W = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;

  // Period window bounds, one bit wider than the counter so period = cnt+1 never wraps.
  localparam logic [CNT_W:0]   PER_LO      = (CNT_W+1)'(NOM_TICKS - TOL);
  localparam logic [CNT_W:0]   PER_HI      = (CNT_W+1)'(NOM_TICKS + TOL);
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(NOM_TICKS + TOL - 1);
  localparam logic [CNT_W-1:0] CNT_WRAP    = CNT_W'(NOM_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_HALF    = CNT_W'(NOM_TICKS / 2);
  localparam logic [CNT_W-1:0] CNT_VIRT    = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic pps_edge;

  pps_edge_sync #(.STAGES(SYNC_STAGES)) u_pps_sync (
    .clk      (clk_250),
    .rst      (rst),
    .async_in (one_pps),
    .rise     (pps_edge)
  );

  pps_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEC_W-1:0]    sec_q, sec_d;
  logic [CNT_W-1:0]    last_q, last_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic [CONS_W-1:0]   consec_q, consec_d;
  logic                missing_q, missing_d;

  logic [CNT_W:0] period;
  logic           win_good, win_early, lock_hit, timeout, sec_inc;

  // Classify the current count against the acceptance window.
  always_comb begin
    period    = {1'b0, cnt_q} + (CNT_W+1)'(1);
    win_good  = (period >= PER_LO) && (period <= PER_HI);
    win_early = (period < PER_LO);
    lock_hit  = (consec_q == CONS_W'(LOCK_N - 1));
    // An edge landing on the last tick of the window is good, so it beats the timeout.
    timeout   = (state_q == ST_LOCKED) && !pps_edge && (cnt_q == CNT_TIMEOUT);
  end

  // State register.
  always_ff @(posedge clk_250) begin
    if (rst) state_q <= ST_UNLOCKED;
    else     state_q <= state_d;
  end

  // Next-state logic for lock acquisition, loss and re-acquisition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNLOCKED: if (pps_edge && win_good && lock_hit) state_d = ST_LOCKED;
      ST_LOCKED:   if (timeout) state_d = ST_HOLDOVER;
      ST_HOLDOVER: if (pps_edge) state_d = ST_UNLOCKED;
      default:     state_d = ST_UNLOCKED;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    pps_state  = state_q;
    pps_locked = (state_q == ST_LOCKED);
  end

  // Tick counter, seconds, qualifier and statistics update per state.
  always_comb begin
    cnt_d     = cnt_q;
    sec_inc   = 1'b0;
    consec_d  = consec_q;
    last_d    = last_q;
    glitch_d  = glitch_q;
    missing_d = 1'b0;
    case (state_q)
      ST_UNLOCKED: begin
        if (pps_edge) begin
          cnt_d   = '0;
          sec_inc = 1'b1;
          if (win_good) begin
            consec_d = lock_hit ? '0 : consec_q + CONS_W'(1);
            last_d   = period[CNT_W-1:0];
          end else begin
            consec_d = '0;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (pps_edge && win_good) begin
          cnt_d   = '0;
          sec_inc = 1'b1;
          last_d  = period[CNT_W-1:0];
        end else if (timeout) begin
          // Virtual PPS at NOM_TICKS: TOL ticks of the new second already elapsed.
          cnt_d     = CNT_VIRT;
          sec_inc   = 1'b1;
          missing_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (pps_edge && win_early && (glitch_q != '1)) glitch_d = glitch_q + GLITCH_W'(1);
        end
      end
      ST_HOLDOVER: begin
        if (pps_edge) begin
          cnt_d    = '0;
          consec_d = '0;
          // Below half a period the flywheel already counted this second.
          sec_inc  = (cnt_q >= CNT_HALF);
        end else if (cnt_q == CNT_WRAP) begin
          cnt_d   = '0;
          sec_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
    sec_d = sec_load ? sec_load_val : sec_q + SEC_W'(sec_inc);
  end

  // Datapath registers.
  always_ff @(posedge clk_250) begin
    if (rst) begin
      cnt_q     <= '0;
      sec_q     <= '0;
      last_q    <= '0;
      glitch_q  <= '0;
      consec_q  <= '0;
      missing_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sec_q     <= sec_d;
      last_q    <= last_d;
      glitch_q  <= glitch_d;
      consec_q  <= consec_d;
      missing_q <= missing_d;
    end
  end

  assign elapsed_time = cnt_q;
  assign seconds      = sec_q;
  assign last_period  = last_q;
  assign glitch_count = glitch_q;
  assign pps_missing  = missing_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ts
    logic             trig_dly_q, trig_dly_d;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] el_q, el_d;
    logic [SEC_W-1:0] sc_q, sc_d;

    // Capture the pre-update time on each trigger rising edge and hold it.
    always_comb begin
      trig_dly_d = ts.trig[i];
      vld_d      = ts.trig[i] & ~trig_dly_q;
      el_d       = vld_d ? cnt_q : el_q;
      sc_d       = vld_d ? sec_q : sc_q;
    end

    // Per-channel timestamp registers.
    always_ff @(posedge clk_250) begin
      if (rst) begin
        trig_dly_q <= 1'b0;
        vld_q      <= 1'b0;
        el_q       <= '0;
        sc_q       <= '0;
      end else begin
        trig_dly_q <= trig_dly_d;
        vld_q      <= vld_d;
        el_q       <= el_d;
        sc_q       <= sc_d;
      end
    end

    assign ts.ts_valid[i]                    = vld_q;
    assign ts.ts_elapsed[i*CNT_W +: CNT_W]   = el_q;
    assign ts.ts_seconds[i*SEC_W +: SEC_W]   = sc_q;
  end
endmodule

// File: doc/pps_elapsed_timer.md
Name: pps_elapsed_timer

Overview:
PPS-disciplined elapsed-time counter with a seconds counter, lock/holdover state machine, glitch rejection, and N_CH trigger-timestamp channels, all in one clock domain. It is the parametrised successor of the per-phase elapsed-time counters. It sits between the board PPS input and the MAROC data-capture logic. Capture logic uses the ts_* outputs to stamp events with {seconds, ticks}.

Parameters:
CNT_W, 29, tick counter width; must satisfy 2^CNT_W > NOM_TICKS+TOL.
SEC_W, 32, seconds counter width; wraps modulo 2^SEC_W.
NOM_TICKS, 250000000, nominal clk_250 cycles per PPS period.
TOL, 1000, accepted period deviation in ticks (+/-).
LOCK_N, 3, consecutive in-window periods required to lock.
SYNC_STAGES, 2, synchroniser flops on one_pps (>=2).
N_CH, 4, number of trigger-timestamp channels.

Ports:
clk_250  in  1  sole clock
rst  in  1  synchronous, active-high reset
one_pps  in  1  asynchronous PPS input
sec_load  in  1  load seconds from sec_load_val (1-cycle strobe)
sec_load_val  in  SEC_W  seconds preset value
trig  in  N_CH  per-channel event inputs, synchronous to clk_250
elapsed_time  out  CNT_W  tick counter (register output)
seconds  out  SEC_W  seconds counter
last_period  out  CNT_W  ticks in last accepted PPS period
pps_state  out  2  0=UNLOCKED 1=LOCKED 2=HOLDOVER
pps_locked  out  1  pps_state==LOCKED
pps_missing  out  1  1-cycle pulse on LOCKED->HOLDOVER
glitch_count  out  16  saturating count of rejected early edges
ts_valid  out  N_CH  per-channel 1-cycle capture strobe
ts_elapsed  out  N_CH*CNT_W  captured elapsed_time (channel i at [i*CNT_W +: CNT_W])
ts_seconds  out  N_CH*SEC_W  captured seconds

Behaviour:
- Reset: all outputs and internal registers are 0, and pps_state is UNLOCKED. Reset is valid at any point, including mid-holdover.
- PPS sync: one_pps passes through a SYNC_STAGES-deep flop chain, followed by one delay flop. edge = sync_out & ~delay.
  - If one_pps is first sampled high at edge k, elapsed_time reads 0 after edge k+SYNC_STAGES.
- Window checks on edge, with cnt = elapsed_time and period = cnt+1:
  - good: |period-NOM_TICKS| <= TOL.
  - early: period < NOM_TICKS-TOL.
- UNLOCKED:
  - cnt increments and saturates at all-ones (no wrap).
  - Every edge sets cnt to 0 and increments seconds.
  - On a good edge, consec increments and last_period is set to period. On any non-good edge, consec is set to 0.
  - When consec reaches LOCK_N, the state moves to LOCKED on that same edge.
- LOCKED:
  - A good edge sets cnt to 0, increments seconds, and updates last_period.
  - An early edge is ignored for counting and increments glitch_count (saturating at 0xFFFF).
  - Timeout: if cnt == NOM_TICKS+TOL-1 with no edge, then next cnt = TOL (a virtual PPS at NOM_TICKS), seconds increments, pps_missing pulses, and the state moves to HOLDOVER.
- HOLDOVER:
  - Flywheel: cnt == NOM_TICKS-1 wraps to 0 and increments seconds.
  - Any edge sets cnt to 0, consec to 0, and the state to UNLOCKED. seconds increments only if cnt >= NOM_TICKS/2; otherwise the flywheel has already counted that second.
- Simultaneous events:
  - sec_load has priority over any increment: seconds = sec_load_val on that cycle, while cnt follows normal rules.
  - Edge and timeout on the same cycle: the edge wins.
  - Edge and flywheel wrap on the same cycle: the edge rule applies.
- Timestamps:
  - Per channel, the rising edge is trig[i] & ~trig_d[i].
  - On that cycle, ts_elapsed[i] and ts_seconds[i] capture the current (pre-update) elapsed_time and seconds. ts_valid[i] is high for the next cycle only, so latency is 1 cycle.
  - Captured values hold until the next capture. Channels are independent, and simultaneous triggers are all captured.

Decomposition:
- Package pps_timer_pkg: the pps_state encoding constants (UNLOCKED/LOCKED/HOLDOVER) and the glitch_count width.
- Sub-module pps_edge_sync: parametrised synchroniser plus rising-edge detector, used for one_pps.
- Timestamp channels are a generate loop inside the top level.

Test Plan:
(Bench params: NOM_TICKS=100, TOL=3, LOCK_N=2, SYNC_STAGES=2, CNT_W=8, N_CH=4.)
1. Reset, then PPS every 100 cycles x3 -> pps_locked rises on the 3rd edge; last_period=100; seconds=3; elapsed_time=0 two cycles after one_pps rises.
2. LOCKED, extra pulse at cnt=40 -> glitch_count=1; cnt continues 41,42,...; next good edge resets cnt; state stays LOCKED.
3. LOCKED, PPS removed -> at cnt=102: pps_missing pulses, cnt becomes 3, seconds+1, state HOLDOVER. Next wrap is 99->0 with seconds+1.
4. HOLDOVER, edge at cnt=10 -> cnt=0, seconds unchanged, state UNLOCKED. Edge at cnt=80 instead -> seconds+1.
5. trig[2] rises on the same cycle as an accepted edge with cnt=99, seconds=5 -> next cycle ts_valid[2]=1, ts_elapsed[2]=99, ts_seconds[2]=5.
6. rst asserted mid-HOLDOVER with sec_load=1 on the same cycle -> all outputs 0, state UNLOCKED (reset wins). A later sec_load with value 1000 -> seconds=1000 on the next cycle.
